// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank slave.
package axil_pkg;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    WR_IDLE    = 3'd0,
    WR_HAVE_AW = 3'd1,
    WR_HAVE_W  = 3'd2,
    WR_COMMIT  = 3'd3,
    WR_RESP    = 3'd4
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // Merge new_val into old_val on the byte lanes enabled by strb.
  function automatic logic [AXIL_DATA_W-1:0] apply_strb(
    input logic [AXIL_DATA_W-1:0] old_val,
    input logic [AXIL_DATA_W-1:0] new_val,
    input logic [AXIL_STRB_W-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slave_regs_if.sv
// AXI4-Lite signal bundle between the bench-side master and the register slave.
interface axil_slave_regs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_reg_bank.sv
// NUM_REGS x 32 register array: one byte-strobed write port, one combinational read port.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_IN_W = 30
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [IDX_IN_W-1:0]    i_wr_idx,
  input  logic [AXIL_DATA_W-1:0] i_wr_data,
  input  logic [AXIL_STRB_W-1:0] i_wr_strb,
  output logic                   o_wr_in_range,
  input  logic [IDX_IN_W-1:0]    i_rd_idx,
  output logic [AXIL_DATA_W-1:0] o_rd_data,
  output logic                   o_rd_in_range
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_IN_W-1:0] LIMIT = IDX_IN_W'(NUM_REGS);

  logic [AXIL_DATA_W-1:0] r_mem [NUM_REGS];
  logic [SEL_W-1:0]       w_wr_sel;
  logic [SEL_W-1:0]       w_rd_sel;

  assign o_wr_in_range = (i_wr_idx < LIMIT);
  assign o_rd_in_range = (i_rd_idx < LIMIT);
  assign w_wr_sel      = i_wr_idx[SEL_W-1:0];
  assign w_rd_sel      = i_rd_idx[SEL_W-1:0];
  assign o_rd_data     = o_rd_in_range ? r_mem[w_rd_sel] : {AXIL_DATA_W{1'b0}};

  // Register storage; out-of-range writes touch nothing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= {AXIL_DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_wr_en && o_wr_in_range && (w_wr_sel == SEL_W'(i))) begin
          r_mem[i] <= apply_strb(r_mem[i], i_wr_data, i_wr_strb);
        end
      end
    end
  end
endmodule

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave register bank, one outstanding transaction per direction.
// Define AXIL_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic            ACLK,
  input logic            ARESETn,
  axil_slave_regs_if.slave s_axil
);
`ifdef AXIL_REGS_SLVERR_EN
  localparam resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam resp_t OOR_RESP = RESP_OKAY;
`endif

  wr_state_t           r_wr_state, w_wr_state_n;
  rd_state_t           r_rd_state, w_rd_state_n;
  logic                r_awready, w_awready_n;
  logic                r_wready, w_wready_n;
  logic                r_bvalid, w_bvalid_n;
  resp_t               r_bresp, w_bresp_n;
  logic [ADDR_W-3:0]   r_awidx;
  logic [DATA_W-1:0]   r_wdata;
  logic [AXIL_STRB_W-1:0] r_wstrb;
  logic                r_arready, w_arready_n;
  logic                r_ar_pending, w_ar_pending_n;
  logic [ADDR_W-3:0]   r_aridx;
  logic                r_rvalid, w_rvalid_n;
  logic [DATA_W-1:0]   r_rdata, w_rdata_n;
  resp_t               r_rresp, w_rresp_n;
  logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                w_wr_en, w_wr_in_range, w_rd_in_range;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_unused;

  assign w_aw_hs  = s_axil.AWVALID && r_awready;
  assign w_w_hs   = s_axil.WVALID && r_wready;
  assign w_b_hs   = r_bvalid && s_axil.BREADY;
  assign w_ar_hs  = s_axil.ARVALID && r_arready;
  assign w_r_hs   = r_rvalid && s_axil.RREADY;
  assign w_unused = ^{s_axil.AWADDR[1:0], s_axil.ARADDR[1:0]};

  axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_IN_W (ADDR_W - 2)
  ) u_bank (
    .i_clk         (ACLK),
    .i_rst_n       (ARESETn),
    .i_wr_en       (w_wr_en),
    .i_wr_idx      (r_awidx),
    .i_wr_data     (r_wdata),
    .i_wr_strb     (r_wstrb),
    .o_wr_in_range (w_wr_in_range),
    .i_rd_idx      (r_aridx),
    .o_rd_data     (w_rd_data),
    .o_rd_in_range (w_rd_in_range)
  );

  // Write channel next state, commit strobe and response.
  always_comb begin
    w_wr_state_n = r_wr_state;
    w_bvalid_n   = r_bvalid;
    w_bresp_n    = r_bresp;
    w_wr_en      = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wr_state_n = WR_COMMIT;
        end else if (w_aw_hs) begin
          w_wr_state_n = WR_HAVE_AW;
        end else if (w_w_hs) begin
          w_wr_state_n = WR_HAVE_W;
        end else begin
          w_wr_state_n = WR_IDLE;
        end
      end
      WR_HAVE_AW: begin
        if (w_w_hs) begin
          w_wr_state_n = WR_COMMIT;
        end else begin
          w_wr_state_n = WR_HAVE_AW;
        end
      end
      WR_HAVE_W: begin
        if (w_aw_hs) begin
          w_wr_state_n = WR_COMMIT;
        end else begin
          w_wr_state_n = WR_HAVE_W;
        end
      end
      WR_COMMIT: begin
        w_wr_en      = 1'b1;
        w_bvalid_n   = 1'b1;
        w_bresp_n    = w_wr_in_range ? RESP_OKAY : OOR_RESP;
        w_wr_state_n = WR_RESP;
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_bvalid_n   = 1'b0;
          w_wr_state_n = WR_IDLE;
        end else begin
          w_wr_state_n = WR_RESP;
        end
      end
      default: begin
        w_wr_state_n = WR_IDLE;
        w_bvalid_n   = 1'b0;
      end
    endcase
    // READYs stay low for the edge that retires a response, returning one edge later.
    w_awready_n = ((w_wr_state_n == WR_IDLE) || (w_wr_state_n == WR_HAVE_W)) &&
                  (r_wr_state != WR_RESP);
    w_wready_n  = ((w_wr_state_n == WR_IDLE) || (w_wr_state_n == WR_HAVE_AW)) &&
                  (r_wr_state != WR_RESP);
  end

  // Write channel state and held AW/W payload.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awidx    <= {(ADDR_W-2){1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_wstrb    <= {AXIL_STRB_W{1'b0}};
    end else begin
      r_wr_state <= w_wr_state_n;
      r_awready  <= w_awready_n;
      r_wready   <= w_wready_n;
      r_bvalid   <= w_bvalid_n;
      r_bresp    <= w_bresp_n;
      if (w_aw_hs) begin
        r_awidx <= s_axil.AWADDR[ADDR_W-1:2];
      end
      if (w_w_hs) begin
        r_wdata <= s_axil.WDATA;
        r_wstrb <= s_axil.WSTRB;
      end
    end
  end

  // Read channel: an accepted address is looked up on the following edge.
  always_comb begin
    w_rd_state_n   = r_rd_state;
    w_ar_pending_n = r_ar_pending;
    w_rvalid_n     = r_rvalid;
    w_rdata_n      = r_rdata;
    w_rresp_n      = r_rresp;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_ar_pending) begin
          w_ar_pending_n = 1'b0;
          w_rvalid_n     = 1'b1;
          w_rdata_n      = w_rd_data;
          w_rresp_n      = w_rd_in_range ? RESP_OKAY : OOR_RESP;
          w_rd_state_n   = RD_RESP;
        end else if (w_ar_hs) begin
          w_ar_pending_n = 1'b1;
        end else begin
          w_ar_pending_n = 1'b0;
        end
      end
      RD_RESP: begin
        if (w_r_hs) begin
          w_rvalid_n   = 1'b0;
          w_rd_state_n = RD_IDLE;
        end else begin
          w_rd_state_n = RD_RESP;
        end
      end
      default: begin
        w_rd_state_n   = RD_IDLE;
        w_ar_pending_n = 1'b0;
        w_rvalid_n     = 1'b0;
      end
    endcase
    w_arready_n = (w_rd_state_n == RD_IDLE) && !w_ar_pending_n && (r_rd_state != RD_RESP);
  end

  // Read channel state, held address and registered response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rd_state   <= RD_IDLE;
      r_arready    <= 1'b0;
      r_ar_pending <= 1'b0;
      r_aridx      <= {(ADDR_W-2){1'b0}};
      r_rvalid     <= 1'b0;
      r_rdata      <= {DATA_W{1'b0}};
      r_rresp      <= RESP_OKAY;
    end else begin
      r_rd_state   <= w_rd_state_n;
      r_arready    <= w_arready_n;
      r_ar_pending <= w_ar_pending_n;
      r_rvalid     <= w_rvalid_n;
      r_rdata      <= w_rdata_n;
      r_rresp      <= w_rresp_n;
      if (w_ar_hs) begin
        r_aridx <= s_axil.ARADDR[ADDR_W-1:2];
      end
    end
  end

  assign s_axil.AWREADY = r_awready;
  assign s_axil.WREADY  = r_wready;
  assign s_axil.BVALID  = r_bvalid;
  assign s_axil.BRESP   = r_bresp;
  assign s_axil.ARREADY = r_arready;
  assign s_axil.RVALID  = r_rvalid;
  assign s_axil.RDATA   = r_rdata;
  assign s_axil.RRESP   = r_rresp;
endmodule

// File: tb/tb_axil_slave_regs.sv
// Self-checking bench for axil_slave_regs against a register-array reference model.
`timescale 1ns/1ps
module tb_axil_slave_regs;
  localparam int NUM_REGS = 16;
`ifdef AXIL_REGS_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: current value, value before the last write, and that write's commit cycle.
  logic [31:0] mem  [NUM_REGS];
  logic [31:0] prev [NUM_REGS];
  int          wcyc [NUM_REGS];

  axil_slave_regs_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_slave_regs #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(NUM_REGS)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axil  (bus)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) begin
      mem[i] = 32'd0; prev[i] = 32'd0; wcyc[i] = -1;
    end
  endtask

  // Drive AW and W independently; returns the cycle of the later handshake.
  task automatic do_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_dly, input int w_dly, output int hs, output bit ok);
    int aw_c, w_c;
    bit aw_ok, w_ok;
    aw_ok = 1'b0; w_ok = 1'b0; aw_c = 0; w_c = 0;
    fork
      begin
        repeat (aw_dly) @(negedge ACLK);
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
          if (bus.AWREADY === 1'b1) begin aw_ok = 1'b1; break; end
          @(negedge ACLK);
        end
        if (aw_ok) @(negedge ACLK);
        aw_c = cyc; bus.AWVALID = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge ACLK);
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
          if (bus.WREADY === 1'b1) begin w_ok = 1'b1; break; end
          @(negedge ACLK);
        end
        if (w_ok) @(negedge ACLK);
        w_c = cyc; bus.WVALID = 1'b0;
      end
    join
    hs = (aw_c > w_c) ? aw_c : w_c;
    ok = aw_ok && w_ok;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int hs, bc, n, idx;
    bit ok, inr;
    logic [1:0] er;
    do_aw_w(addr, data, strb, aw_dly, w_dly, hs, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wr_handshake addr=%h: ready never seen", addr); return;
    end
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    bc = cyc;
    checks++;
    if (bus.BVALID !== 1'b1 || bc != hs + 1)
      begin errors++; $display("FAIL wr_latency addr=%h: bvalid=%b after %0d cycles, required 1", addr, bus.BVALID, bc - hs); end
    idx = int'(addr[31:2]);
    inr = (idx < NUM_REGS);
    if (inr) begin prev[idx] = mem[idx]; mem[idx] = merge(mem[idx], data, strb); wcyc[idx] = bc; end
    er = inr ? 2'b00 : EXP_OOR;
    for (int i = 0; i < b_dly; i++) begin
      checks++;
      if (bus.BVALID !== 1'b1 || bus.BRESP !== er || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0)
        begin errors++; $display("FAIL wr_hold: bvalid=%b bresp=%b awready=%b wready=%b, required 1 %b 0 0", bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, er); end
      @(negedge ACLK);
    end
    checks++;
    if (bus.BRESP !== er) begin errors++; $display("FAIL wr_bresp addr=%h: got %b required %b", addr, bus.BRESP, er); end
    bus.BREADY = 1'b1; @(negedge ACLK); bus.BREADY = 1'b0;
    checks++;
    if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0)
      begin errors++; $display("FAIL wr_release: bvalid=%b awready=%b wready=%b, required 0 0 0", bus.BVALID, bus.AWREADY, bus.WREADY); end
    @(negedge ACLK);
    checks++;
    if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1)
      begin errors++; $display("FAIL wr_ready_return: bvalid=%b awready=%b wready=%b, required 0 1 1", bus.BVALID, bus.AWREADY, bus.WREADY); end
  endtask

  task automatic read_txn(input logic [31:0] addr, input int ar_dly, input int r_dly, output logic [31:0] got);
    int hs, rc, n, idx;
    bit ok, inr;
    logic [31:0] ed;
    logic [1:0] er;
    got = 32'd0; ok = 1'b0;
    repeat (ar_dly) @(negedge ACLK);
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (bus.ARREADY === 1'b1) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    if (ok) @(negedge ACLK);
    hs = cyc; bus.ARVALID = 1'b0;
    checks++;
    if (!ok || bus.ARREADY !== 1'b0)
      begin errors++; $display("FAIL rd_handshake addr=%h: ok=%b arready=%b, required 1 0", addr, ok, bus.ARREADY); return; end
    n = 0;
    while (bus.RVALID !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    rc = cyc;
    checks++;
    if (bus.RVALID !== 1'b1 || rc != hs + 1)
      begin errors++; $display("FAIL rd_latency addr=%h: rvalid=%b after %0d cycles, required 1", addr, bus.RVALID, rc - hs); end
    idx = int'(addr[31:2]);
    inr = (idx < NUM_REGS);
    ed = !inr ? 32'd0 : ((wcyc[idx] == rc) ? prev[idx] : mem[idx]);
    er = inr ? 2'b00 : EXP_OOR;
    got = bus.RDATA;
    checks++;
    if (bus.RDATA !== ed || bus.RRESP !== er)
      begin errors++; $display("FAIL rd_data addr=%h: rdata=%h rresp=%b, required %h %b", addr, bus.RDATA, bus.RRESP, ed, er); end
    for (int i = 0; i < r_dly; i++) begin
      @(negedge ACLK);
      checks++;
      if (bus.RVALID !== 1'b1 || bus.RDATA !== ed || bus.RRESP !== er || bus.ARREADY !== 1'b0)
        begin errors++; $display("FAIL rd_hold: rvalid=%b rdata=%h arready=%b, required 1 %h 0", bus.RVALID, bus.RDATA, bus.ARREADY, ed); end
    end
    bus.RREADY = 1'b1; @(negedge ACLK); bus.RREADY = 1'b0;
    checks++;
    if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b0)
      begin errors++; $display("FAIL rd_release: rvalid=%b arready=%b, required 0 0", bus.RVALID, bus.ARREADY); end
    @(negedge ACLK);
    checks++;
    if (bus.ARREADY !== 1'b1)
      begin errors++; $display("FAIL rd_ready_return: arready=%b, required 1", bus.ARREADY); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID} !== 5'b0 ||
        bus.BRESP !== 2'b00 || bus.RRESP !== 2'b00 || bus.RDATA !== 32'd0)
      begin errors++; $display("FAIL %s: rdy/vld=%b bresp=%b rresp=%b rdata=%h, required all zero", tag,
            {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID}, bus.BRESP, bus.RRESP, bus.RDATA); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset_outputs");
    ARESETn = 1'b1;
    checks++;
    if (bus.AWREADY !== 1'b0) begin errors++; $display("FAIL reset_ready_early: awready=%b required 0", bus.AWREADY); end
    @(negedge ACLK);
    checks++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111)
      begin errors++; $display("FAIL reset_ready_rise: ready=%b required 111", {bus.AWREADY, bus.WREADY, bus.ARREADY}); end
  endtask

  task automatic test_basic();
    logic [31:0] got;
    write_txn(32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    read_txn(32'h0000_0000, 0, 0, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rdata: got %h required DEADBEEF", got); end
  endtask

  task automatic test_strobe();
    logic [31:0] got;
    write_txn(32'h0000_0004, 32'h1234_5678, 4'hF, 0, 0, 0);
    write_txn(32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    read_txn(32'h0000_0006, 0, 0, got);
    checks++;
    if (got !== 32'h12BB_56DD) begin errors++; $display("FAIL strobe_rdata: got %h required 12BB56DD", got); end
  endtask

  task automatic test_order();
    logic [31:0] got;
    write_txn(32'h0000_0008, 32'hA5A5_0001, 4'hF, 3, 0, 0);
    write_txn(32'h0000_000C, 32'h5A5A_0002, 4'hF, 0, 3, 0);
    read_txn(32'h0000_0008, 0, 0, got);
    read_txn(32'h0000_000C, 0, 0, got);
    checks++;
    if (got !== 32'h5A5A_0002) begin errors++; $display("FAIL order_rdata: got %h required 5A5A0002", got); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got;
    write_txn(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
    read_txn(32'h0000_0020, 0, 5, got);
  endtask

  task automatic test_out_of_range();
    logic [31:0] got;
    write_txn(32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    write_txn(32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
    read_txn(32'h0000_0040, 0, 0, got);
    read_txn(32'h0000_007C, 0, 1, got);
    read_txn(32'h0000_003F, 0, 0, got);
    for (int i = 0; i < NUM_REGS; i++) read_txn(32'(i * 4), 0, 0, got);
  endtask

  task automatic test_same_edge();
    logic [31:0] got;
    write_txn(32'h0000_0014, 32'h1111_1111, 4'hF, 0, 0, 0);
    fork
      write_txn(32'h0000_0014, 32'h2222_2222, 4'hF, 0, 0, 0);
      read_txn(32'h0000_0014, 0, 0, got);
    join
    checks++;
    if (got !== 32'h1111_1111) begin errors++; $display("FAIL same_edge_rdata: got %h required 11111111", got); end
    read_txn(32'h0000_0014, 0, 0, got);
  endtask

  task automatic test_random();
    logic [31:0] got, wa, ra;
    for (int it = 0; it < 60; it++) begin
      wa = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      ra = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      fork
        write_txn(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        read_txn(ra, $urandom_range(0, 3), $urandom_range(0, 2), got);
      join
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    int hs;
    bit ok;
    do_aw_w(32'h0000_0010, 32'h7777_7777, 4'hF, 0, 0, hs, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_handshake: ready never seen"); end
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("abort_outputs");
    model_clear();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++;
    if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1)
      begin errors++; $display("FAIL abort_no_resp: bvalid=%b awready=%b required 0 1", bus.BVALID, bus.AWREADY); end
    for (int i = 0; i < NUM_REGS; i++) read_txn(32'(i * 4), 0, 0, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AWADDR = 32'd0; bus.AWVALID = 1'b0; bus.WDATA = 32'd0; bus.WSTRB = 4'd0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = 32'd0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_strobe();
    test_order();
    test_backpressure();
    test_out_of_range();
    test_same_edge();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
